// File: rtl/cmd_seq_pkg.sv
// Shared types and constants for the command sequencer: state encoding,
// error codes and the default positive-acknowledge byte.
package cmd_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LOAD   = 3'd1;
  localparam state_t ST_SEND   = 3'd2;
  localparam state_t ST_WAIT   = 3'd3;
  localparam state_t ST_RETIRE = 3'd4;
  localparam state_t ST_ERR    = 3'd5;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_NACK = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  localparam logic [7:0] ACK_DEFAULT = 8'hA5;

endpackage

// File: rtl/cmd_seq_if.sv
// Command/response handshake between the sequencer (master) and RemoteComm (slave).
interface cmd_seq_if #(
  parameter int CMD_W = 16
);
  logic             send_cmd;
  logic [CMD_W-1:0] cmd;
  logic             cmd_sent;
  logic             resp_rdy;
  logic [7:0]       resp;

  modport master (output send_cmd, cmd, input cmd_sent, resp_rdy, resp);
  modport slave  (input send_cmd, cmd, output cmd_sent, resp_rdy, resp);
endinterface

// File: rtl/cmd_fifo.sv
// Command queue: DEPTH-entry FIFO with registered full/empty/one flags and a
// synchronous flush that discards all entries.
module cmd_fifo #(
  parameter int CMD_W = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_req,
  input  logic [CMD_W-1:0] wr_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CMD_W-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             one
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_nx;
  logic             push, do_pop;

  // A push is dropped whenever the queue is full, even alongside a pop.
  assign push   = push_req && !full && !flush;
  assign do_pop = pop && !empty && !flush;
  assign head   = mem[rd_ptr];

  always_comb begin
    count_nx = count;
    case ({push, do_pop})
      2'b10:   count_nx = count + 1'b1;
      2'b01:   count_nx = count - 1'b1;
      default: count_nx = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      one    <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      one    <= 1'b0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nx;
      full  <= (count_nx == FULL_CNT);
      empty <= (count_nx == '0);
      one   <= (count_nx == {{AW{1'b0}}, 1'b1});
    end
  end

endmodule

// File: rtl/cmd_sequencer.sv
// Issues queued commands one at a time to RemoteComm, times out and checks
// each response, and keeps pass/fail counts plus the first error.
module cmd_sequencer
  import cmd_seq_pkg::*;
#(
  parameter int         CMD_W       = 16,
  parameter int         DEPTH       = 8,
  parameter int         TMO_W       = 20,
  parameter int         TIMEOUT     = 1000000,
  parameter logic [7:0] ACK_VAL     = ACK_DEFAULT,
  parameter bit         STOP_ON_ERR = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [CMD_W-1:0] wr_cmd,
  output logic             full,
  output logic             empty,
  input  logic             start,
  input  logic             clr,
  output logic             busy,
  output logic             done,
  cmd_seq_if.master        rc,
  output logic [7:0]       pass_cnt,
  output logic [7:0]       fail_cnt,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [7:0]       err_idx
);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_t           state;
  logic [TMO_W-1:0] timer;
  logic [7:0]       idx;
  logic [CMD_W-1:0] cmd_q, head;
  logic             send_q, done_q;
  logic             fifo_one, pop, flush, will_empty;
  logic             got_resp, ack, tmo_hit, fail;
  logic             unused_status;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  cmd_fifo #(.CMD_W(CMD_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push_req(wr_en), .wr_data(wr_cmd),
    .pop(pop), .flush(flush), .head(head), .full(full), .empty(empty), .one(fifo_one)
  );

  // A response on the timeout cycle still counts as an answer.
  assign got_resp   = (state == ST_WAIT) && rc.resp_rdy;
  assign ack        = got_resp && (rc.resp == ACK_VAL);
  assign tmo_hit    = (state == ST_WAIT) && !rc.resp_rdy && (timer == TMO_LAST);
  assign fail       = (got_resp && !ack) || tmo_hit;
  assign pop        = (state == ST_RETIRE) && !clr;
  assign flush      = (fail && STOP_ON_ERR && !clr) || ((state == ST_ERR) && clr);
  assign will_empty = fifo_one && !(wr_en && !full);

  assign rc.send_cmd   = send_q;
  assign rc.cmd        = cmd_q;
  assign done          = done_q;
  assign busy          = (state != ST_IDLE) && (state != ST_ERR);
  assign unused_status = rc.cmd_sent;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      timer    <= '0;
      idx      <= '0;
      cmd_q    <= '0;
      send_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
      err_idx  <= '0;
    end else begin
      send_q <= 1'b0;
      done_q <= 1'b0;
      if (clr) begin
        state    <= ST_IDLE;
        idx      <= '0;
        pass_cnt <= '0;
        fail_cnt <= '0;
        err      <= 1'b0;
        err_code <= ERR_NONE;
        err_idx  <= '0;
      end else begin
        case (state)
          ST_IDLE: if (start && !empty) state <= ST_LOAD;
          ST_LOAD: begin
            cmd_q  <= head;
            timer  <= '0;
            send_q <= 1'b1;
            state  <= ST_SEND;
          end
          ST_SEND: begin
            timer <= timer + 1'b1;
            state <= ST_WAIT;
          end
          ST_WAIT: begin
            timer <= timer + 1'b1;
            if (ack) begin
              pass_cnt <= sat_inc(pass_cnt);
              state    <= ST_RETIRE;
            end else if (fail) begin
              fail_cnt <= sat_inc(fail_cnt);
              if (!err) begin
                err      <= 1'b1;
                err_code <= got_resp ? ERR_NACK : ERR_TMO;
                err_idx  <= idx;
              end
              state <= STOP_ON_ERR ? ST_ERR : ST_RETIRE;
            end
          end
          ST_RETIRE: begin
            idx <= idx + 8'd1;
            if (will_empty) begin
              done_q <= 1'b1;
              state  <= ST_IDLE;
            end else begin
              state <= ST_LOAD;
            end
          end
          ST_ERR:  state <= ST_ERR;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Bench for cmd_sequencer: two instances (halt-on-error with a short timeout,
// log-and-continue with a longer one) driven by directed and random sequences.
module tb_cmd_sequencer;
  localparam int CW    = 16;
  localparam int DEPTH = 8;
  localparam int TMO_A = 100;
  localparam int TMO_B = 600;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, sel, wr_en, start, clr, resp_rdy;
  logic [CW-1:0] wr_cmd;
  logic [7:0]    resp;

  logic       full_a, empty_a, busy_a, done_a, err_a;
  logic       full_b, empty_b, busy_b, done_b, err_b;
  logic [7:0] pass_a, fail_a, eidx_a, pass_b, fail_b, eidx_b;
  logic [1:0] code_a, code_b;

  cmd_seq_if #(.CMD_W(CW)) rc_a ();
  cmd_seq_if #(.CMD_W(CW)) rc_b ();

  assign rc_a.cmd_sent = 1'b0;
  assign rc_a.resp_rdy = resp_rdy & ~sel;
  assign rc_a.resp     = resp;
  assign rc_b.cmd_sent = 1'b0;
  assign rc_b.resp_rdy = resp_rdy & sel;
  assign rc_b.resp     = resp;

  cmd_sequencer #(.CMD_W(CW), .DEPTH(DEPTH), .TMO_W(20), .TIMEOUT(TMO_A),
                  .ACK_VAL(8'hA5), .STOP_ON_ERR(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en & ~sel), .wr_cmd(wr_cmd),
    .full(full_a), .empty(empty_a), .start(start & ~sel), .clr(clr & ~sel),
    .busy(busy_a), .done(done_a), .rc(rc_a), .pass_cnt(pass_a), .fail_cnt(fail_a),
    .err(err_a), .err_code(code_a), .err_idx(eidx_a)
  );

  cmd_sequencer #(.CMD_W(CW), .DEPTH(DEPTH), .TMO_W(20), .TIMEOUT(TMO_B),
                  .ACK_VAL(8'hA5), .STOP_ON_ERR(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en & sel), .wr_cmd(wr_cmd),
    .full(full_b), .empty(empty_b), .start(start & sel), .clr(clr & sel),
    .busy(busy_b), .done(done_b), .rc(rc_b), .pass_cnt(pass_b), .fail_cnt(fail_b),
    .err(err_b), .err_code(code_b), .err_idx(eidx_b)
  );

  // Outputs of whichever instance is currently selected
  logic          o_full, o_empty, o_busy, o_done, o_err, o_send;
  logic [7:0]    o_pass, o_fail, o_eidx;
  logic [1:0]    o_code;
  logic [CW-1:0] o_cmd;
  assign o_full  = sel ? full_b  : full_a;
  assign o_empty = sel ? empty_b : empty_a;
  assign o_busy  = sel ? busy_b  : busy_a;
  assign o_done  = sel ? done_b  : done_a;
  assign o_err   = sel ? err_b   : err_a;
  assign o_send  = sel ? rc_b.send_cmd : rc_a.send_cmd;
  assign o_cmd   = sel ? rc_b.cmd : rc_a.cmd;
  assign o_pass  = sel ? pass_b  : pass_a;
  assign o_fail  = sel ? fail_b  : fail_a;
  assign o_eidx  = sel ? eidx_b  : eidx_a;
  assign o_code  = sel ? code_b  : code_a;

  int cyc = 0;
  int n_send = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (o_send === 1'b1) n_send++;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [CW-1:0] exp_cmd[$];
  int            dly[$];
  logic [7:0]    rv[$];
  int            exp_pass, exp_fail, exp_idx, start_cyc;
  logic          exp_err;
  logic [1:0]    exp_code;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [CW-1:0] c);
    wr_en = 1'b1; wr_cmd = c;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_cmd.delete(); dly.delete(); rv.delete();
    exp_pass = 0; exp_fail = 0; exp_idx = 0; exp_err = 1'b0; exp_code = 2'b00;
  endtask

  task automatic plan(input logic [CW-1:0] c, input int d, input logic [7:0] v);
    push(c);
    exp_cmd.push_back(c); dly.push_back(d); rv.push_back(v);
  endtask

  task automatic note_fail(input int i, input logic [1:0] code);
    exp_fail++;
    if (!exp_err) begin
      exp_err = 1'b1; exp_code = code; exp_idx = i;
    end
  endtask

  // Answers each queued command per its plan and checks order, timing and counts.
  task automatic serve(input int n, input int tmo);
    int t, s, nxt, n0;
    n0  = n_send;
    nxt = start_cyc + 2;
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (o_send !== 1'b1 && t < tmo + 50) begin tick(); t++; end
      chk("send_seen", o_send, 1);
      if (o_send !== 1'b1) return;
      s = cyc;
      chk("send_cycle", s, nxt);
      chk("send_cmd_value", o_cmd, exp_cmd[i]);
      tick();
      if (dly[i] > 0) begin
        repeat (dly[i] - 1) tick();
        resp_rdy = 1'b1; resp = rv[i];
        tick();
        resp_rdy = 1'b0;
      end
      if (dly[i] > 0 && dly[i] < tmo) begin
        nxt = s + dly[i] + 3;
        if (rv[i] == 8'hA5) exp_pass++;
        else note_fail(i, 2'b01);
      end else begin
        nxt = s + tmo - 1 + 3;
        note_fail(i, 2'b10);
      end
    end
    t = 0;
    while (o_done !== 1'b1 && t < tmo + 20) begin tick(); t++; end
    chk("done_pulse", o_done, 1);
    tick();
    chk("done_one_cycle", o_done, 0);
    chk("busy_after_done", o_busy, 0);
    chk("send_count", n_send - n0, n);
    chk("pass_cnt", o_pass, exp_pass);
    chk("fail_cnt", o_fail, exp_fail);
    chk("err", o_err, exp_err);
    chk("err_code", o_code, exp_code);
    chk("err_idx", o_eidx, exp_idx);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, t, s, n0;
    logic [CW-1:0] c;
    logic [7:0] v;
    rst_n = 1'b0; sel = 1'b0; wr_en = 1'b0; start = 1'b0; clr = 1'b0;
    resp_rdy = 1'b0; wr_cmd = '0; resp = '0;
    exp_pass = 0; exp_fail = 0; exp_idx = 0; exp_err = 1'b0; exp_code = 2'b00; start_cyc = 0;
    repeat (3) tick();

    // Reset values
    chk("rst_empty", o_empty, 1);
    chk("rst_full", o_full, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_send", o_send, 0);
    chk("rst_cmd", o_cmd, 0);
    chk("rst_counts", {o_pass, o_fail, o_eidx}, 0);
    chk("rst_err", {o_err, o_code}, 0);
    chk("rst_b_outputs", {full_b, busy_b, done_b, rc_b.send_cmd, pass_b, fail_b, err_b, code_b}, 0);
    chk("rst_b_empty", empty_b, 1);
    rst_n = 1'b1;
    tick();

    // Instance B: log-and-continue, TIMEOUT=600
    sel = 1'b1; tick();
    do_clr();
    pulse_start();
    repeat (5) tick();
    chk("start_on_empty_no_send", n_send, 0);
    chk("start_on_empty_idle", o_busy, 0);

    do_clr();
    plan(16'h0000, 500, 8'hA5);
    pulse_start();
    serve(1, TMO_B);

    do_clr();
    plan(16'h0000, 7, 8'hA5);
    plan(16'h23FF, 12, 8'hA5);
    pulse_start();
    serve(2, TMO_B);

    do_clr();
    plan(16'h1111, 4, 8'hA5);
    plan(16'h2222, 9, 8'h5A);
    plan(16'h3333, 3, 8'hA5);
    pulse_start();
    serve(3, TMO_B);

    for (int r = 0; r < 4; r++) begin
      do_clr();
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        c = 16'($urandom);
        k = $urandom_range(0, 9);
        v = 8'($urandom);
        if (v == 8'hA5) v = 8'h00;
        case (k)
          6:       plan(c, $urandom_range(1, 30), v);
          7:       plan(c, TMO_B - 1, 8'hA5);
          8:       plan(c, 0, 8'h00);
          9:       plan(c, TMO_B + $urandom_range(0, 1), 8'hA5);
          default: plan(c, $urandom_range(1, 30), 8'hA5);
        endcase
      end
      pulse_start();
      serve(n, TMO_B);
    end

    // Instance A: halt-on-error, TIMEOUT=100
    sel = 1'b0; tick();
    do_clr();
    push(16'hAAAA); push(16'hBBBB); push(16'hCCCC);
    pulse_start();
    t = 0;
    while (o_send !== 1'b1 && t < 20) begin tick(); t++; end
    chk("tmo_send_seen", o_send, 1);
    chk("tmo_cmd", o_cmd, 16'hAAAA);
    s = cyc; n0 = n_send;
    while (cyc < s + TMO_A - 1) tick();
    chk("tmo_not_yet", o_err, 0);
    tick();
    chk("tmo_err", o_err, 1);
    chk("tmo_code", o_code, 2'b10);
    chk("tmo_idx", o_eidx, 0);
    chk("tmo_fail_cnt", o_fail, 1);
    chk("tmo_pass_cnt", o_pass, 0);
    chk("tmo_halted", o_busy, 0);
    chk("tmo_flushed", o_empty, 1);
    push(16'hDDDD);
    chk("push_in_err", o_empty, 0);
    pulse_start();
    repeat (20) tick();
    chk("no_send_in_err", n_send - n0, 0);
    chk("still_err", {o_busy, o_err}, 2'b01);
    do_clr();
    chk("clr_err", {o_err, o_code}, 0);
    chk("clr_counts", {o_pass, o_fail, o_eidx}, 0);
    chk("clr_flush_from_err", o_empty, 1);
    chk("clr_idle", o_busy, 0);

    // Response exactly on the last timer cycle is a pass
    plan(16'h1234, TMO_A - 1, 8'hA5);
    pulse_start();
    serve(1, TMO_A);

    // Full queue: the ninth push is dropped
    do_clr();
    for (int i = 0; i < DEPTH; i++) begin
      chk("not_full_yet", o_full, 0);
      plan(16'h4000 + 16'(i), 2 + i, 8'hA5);
    end
    chk("full_after_depth", o_full, 1);
    push(16'hFFFF);
    chk("full_held", o_full, 1);
    pulse_start();
    n0 = n_send;
    serve(DEPTH, TMO_A);
    repeat (10) tick();
    chk("dropped_not_sent", n_send - n0, DEPTH);
    chk("empty_after_drain", o_empty, 1);

    // Asynchronous reset while waiting for a response
    do_clr();
    push(16'h5555); push(16'h6666);
    pulse_start();
    t = 0;
    while (o_send !== 1'b1 && t < 20) begin tick(); t++; end
    repeat (10) tick();
    chk("pre_rst_busy", o_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", o_busy, 0);
    chk("arst_send", o_send, 0);
    chk("arst_empty", o_empty, 1);
    chk("arst_cmd", o_cmd, 0);
    chk("arst_outputs", {o_full, o_done, o_err, o_code, o_pass, o_fail, o_eidx}, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    n0 = n_send;
    pulse_start();
    repeat (20) tick();
    chk("post_rst_no_send", n_send - n0, 0);
    chk("post_rst_idle", o_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cmd_sequencer.md
Name: cmd_sequencer

Overview:
Synthesizable, parametrised command sequencer that replaces hand-scripted single-command stimulus. It holds a queue of DEPTH commands and issues them one at a time over the send_cmd/cmd_sent/resp_rdy/resp handshake of RemoteComm. It applies a per-command response timeout and checks each response against the positive-ack byte. It keeps pass/fail counts and reports the first error. It sits between a host or bench loader and RemoteComm, in front of MazeRunner.

Parameters:
CMD_W, 16, command width in bits.
DEPTH, 8, queue depth in entries; power of two, at least 2.
TMO_W, 20, timeout counter width.
TIMEOUT, 1000000, cycles allowed from send_cmd to resp_rdy; must fit in TMO_W bits.
ACK_VAL, 8'hA5, response byte treated as a positive acknowledge.
STOP_ON_ERR, 1, 1 = halt and flush on first failure; 0 = log the failure and continue.

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
wr_en  in  1  push wr_cmd into the queue
wr_cmd  in  CMD_W  command to enqueue
full  out  1  queue full
empty  out  1  queue empty
start  in  1  one-cycle pulse; begins issuing queued commands
clr  in  1  clears counters and error state; returns the block to IDLE
busy  out  1  high in every state except IDLE and ERR
done  out  1  one-cycle pulse when the queue drains with no halt
send_cmd  out  1  one-cycle pulse to RemoteComm
cmd  out  CMD_W  command to RemoteComm; held stable from SEND until the command retires
cmd_sent  in  1  RemoteComm finished transmitting (status only)
resp_rdy  in  1  response byte valid
resp  in  8  response byte
pass_cnt  out  8  commands acknowledged with ACK_VAL; saturates at 255
fail_cnt  out  8  commands that failed (NACK or timeout); saturates at 255
err  out  1  sticky; set on the first failure
err_code  out  2  00 none, 01 NACK, 10 timeout
err_idx  out  8  sequence index (from 0 since start) of the first failure

Behaviour:
- Reset values: all outputs 0 except empty=1. Queue pointers, timer, index and state are cleared; state = IDLE.
- Queue (FIFO):
  - A push occurs when wr_en && !full, in any state.
  - wr_en while full is dropped, even if a pop happens in the same cycle.
  - Simultaneous push and pop on a non-full queue: the count is unchanged.
  - full and empty are registered flags derived from the count.
  - Pointers wrap modulo DEPTH.
- State machine: IDLE, LOAD, SEND, WAIT, RETIRE, ERR.
  - IDLE: start && !empty -> LOAD. start while empty -> stay in IDLE with no done pulse. start in any other state is ignored.
  - LOAD: cmd <= head of queue; timer cleared -> SEND.
  - SEND: send_cmd=1 for exactly one cycle -> WAIT. Timer starts counting on the next cycle.
  - WAIT: timer increments every cycle.
    - resp_rdy && resp==ACK_VAL: pass_cnt++ -> RETIRE.
    - resp_rdy && resp!=ACK_VAL: NACK failure.
    - timer==TIMEOUT-1 with no resp_rdy: timeout failure.
    - If resp_rdy arrives on the same cycle the timer reaches TIMEOUT-1, the response wins.
  - On a failure: fail_cnt++.
    - If err is not already set: err=1, err_code and err_idx recorded.
    - STOP_ON_ERR=1: go to ERR.
    - STOP_ON_ERR=0: go to RETIRE.
  - RETIRE: pop the head entry; idx++ (wraps at 256).
    - If the queue is now empty (no concurrent push): done=1 for one cycle -> IDLE.
    - Otherwise -> LOAD. There is no gap beyond LOAD/SEND.
  - ERR: queue flushed (pointers reset) on entry. The block holds until clr -> IDLE.
- cmd_sent is ignored for sequencing. resp_rdy outside WAIT is ignored.
- clr:
  - Zeroes pass_cnt, fail_cnt, err, err_code, err_idx and idx.
  - Forces IDLE from any state and aborts any in-flight command.
  - Does not flush the queue except when taken from ERR.
- Asynchronous reset mid-WAIT: abandons the command immediately; no send_cmd glitch.
- Latency: start to send_cmd is 2 cycles (LOAD, SEND). An acknowledged resp_rdy to the next send_cmd is 3 cycles.

Decomposition:
- Package cmd_seq_pkg holds:
  - the state enum typedef;
  - localparams ERR_NONE=2'b00, ERR_NACK=2'b01, ERR_TMO=2'b10;
  - default ACK_VAL 8'hA5.
- Sub-module cmd_fifo(CMD_W, DEPTH) owns the storage, pointers and full/empty flags, and has a flush input.
- cmd_sequencer owns the FSM, timer and counters.

Test Plan:
- Single command: push 16'h0000, start; model returns resp=8'hA5 500 cycles after send_cmd -> exactly one send_cmd with cmd=16'h0000, pass_cnt=1, done pulses, err=0.
- Two commands: push 16'h0000 then 16'h23FF; both acknowledged -> send_cmd order is 0000 then 23FF, the second send_cmd comes 3 cycles after the first resp_rdy, pass_cnt=2.
- Timeout: TIMEOUT=100, no response to the first of 3 commands -> at cycle 100 after send_cmd: err=1, err_code=10, err_idx=0, state ERR, empty=1, no further send_cmd. Then clr -> IDLE with counters at 0.
- NACK with STOP_ON_ERR=0: 3 commands; the second answered with 8'h5A -> fail_cnt=1, pass_cnt=2, err_code=01, err_idx=1, done pulses.
- Full and boundaries:
  - Push DEPTH+1 commands -> full=1 after DEPTH pushes; the extra entry is dropped; exactly DEPTH commands are sent.
  - resp_rdy on the same cycle the timer hits TIMEOUT-1 -> counted as a pass.
- Reset mid-WAIT: assert rst_n low during WAIT -> all outputs return to reset values asynchronously, empty=1; after release, start produces no send_cmd.
